// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle control path:
// FSM states, opcode/fn values, and control-field codes.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b000001;
  localparam logic [5:0] OP_STORE = 6'b000010;
  localparam logic [5:0] OP_B     = 6'b100000;
  localparam logic [5:0] OP_BR    = 6'b100001;
  localparam logic [5:0] OP_CALL  = 6'b101000;
  localparam logic [5:0] OP_RET   = 6'b101001;
  localparam logic [5:0] OP_BZ    = 6'b110001;
  localparam logic [5:0] OP_BNZ   = 6'b110010;
  localparam logic [5:0] OP_BCY   = 6'b110011;
  localparam logic [5:0] OP_BSGN  = 6'b110100;

  localparam logic [5:0] FN_ADD  = 6'b000001;
  localparam logic [5:0] FN_COMP = 6'b000010;
  localparam logic [5:0] FN_AND  = 6'b000011;
  localparam logic [5:0] FN_XOR  = 6'b000100;
  localparam logic [5:0] FN_SHLL = 6'b000101;
  localparam logic [5:0] FN_SHRL = 6'b000110;
  localparam logic [5:0] FN_SHRA = 6'b000111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_COMP = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SHLL = 3'b100;
  localparam logic [2:0] ALU_SHRL = 3'b101;
  localparam logic [2:0] ALU_SHRA = 3'b110;

  localparam logic [1:0] RD_RD    = 2'b00;
  localparam logic [1:0] RD_RT    = 2'b01;
  localparam logic [1:0] RD_LINK  = 2'b10;
  localparam logic [1:0] ASRC_REG = 2'b00;
  localparam logic [1:0] ASRC_IMM = 2'b01;
  localparam logic [1:0] ASRC_SHT = 2'b10;
  localparam logic [1:0] FLG_ZERO = 2'b00;
  localparam logic [1:0] FLG_NZ   = 2'b01;
  localparam logic [1:0] FLG_CY   = 2'b10;
  localparam logic [1:0] FLG_SGN  = 2'b11;

  // Instruction class steers the EXEC/MEM successor states.
  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [1:0] regdst;
    logic [1:0] flag;
    logic       branch;
    logic       brnoeq;
    logic       gotoreg;
    logic       onlygoto;
    logic       call;
    logic       ret;
    logic       memtoreg;
    logic [1:0] alusrc;
    logic [2:0] aluctr;
  } ctl_t;

  localparam ctl_t CTL_NONE = '0;

endpackage

// File: rtl/kgp_decoder.sv
// Combinational opcode/fn decoder producing the control bundle and an
// illegal-instruction flag.
module kgp_decoder
  import kgp_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic [OPW-1:0] instruction,
  input  logic [FNW-1:0] fn,
  output ctl_t           ctl,
  output logic           illegal
);

  always_comb begin
    ctl     = CTL_NONE;
    illegal = 1'b0;
    case (instruction)
      OPW'(OP_RTYPE): begin
        ctl.cls = CLS_ALU;
        case (fn)
          FNW'(FN_ADD):  ctl.aluctr = ALU_ADD;
          FNW'(FN_COMP): ctl.aluctr = ALU_COMP;
          FNW'(FN_AND):  ctl.aluctr = ALU_AND;
          FNW'(FN_XOR):  ctl.aluctr = ALU_XOR;
          FNW'(FN_SHLL): begin ctl.aluctr = ALU_SHLL; ctl.alusrc = ASRC_SHT; end
          FNW'(FN_SHRL): begin ctl.aluctr = ALU_SHRL; ctl.alusrc = ASRC_SHT; end
          FNW'(FN_SHRA): begin ctl.aluctr = ALU_SHRA; ctl.alusrc = ASRC_SHT; end
          default:       illegal = 1'b1;
        endcase
      end
      OPW'(OP_LOAD): begin
        ctl.cls      = CLS_LOAD;
        ctl.memtoreg = 1'b1;
        ctl.alusrc   = ASRC_IMM;
        ctl.regdst   = RD_RT;
      end
      OPW'(OP_STORE): begin
        ctl.cls    = CLS_STORE;
        ctl.alusrc = ASRC_IMM;
      end
      OPW'(OP_B):    begin ctl.cls = CLS_BRANCH; ctl.onlygoto = 1'b1; end
      OPW'(OP_BR):   begin ctl.cls = CLS_BRANCH; ctl.gotoreg  = 1'b1; end
      OPW'(OP_BZ):   begin ctl.cls = CLS_BRANCH; ctl.branch = 1'b1; ctl.flag = FLG_ZERO; end
      OPW'(OP_BNZ): begin
        ctl.cls    = CLS_BRANCH;
        ctl.branch = 1'b1;
        ctl.brnoeq = 1'b1;
        ctl.flag   = FLG_NZ;
      end
      OPW'(OP_BCY):  begin ctl.cls = CLS_BRANCH; ctl.branch = 1'b1; ctl.flag = FLG_CY;  end
      OPW'(OP_BSGN): begin ctl.cls = CLS_BRANCH; ctl.branch = 1'b1; ctl.flag = FLG_SGN; end
      OPW'(OP_CALL): begin ctl.cls = CLS_BRANCH; ctl.call = 1'b1; ctl.regdst = RD_LINK; end
      OPW'(OP_RET):  begin ctl.cls = CLS_BRANCH; ctl.ret = 1'b1; ctl.gotoreg = 1'b1; end
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle KGP-RISC control FSM: FETCH/DECODE/EXEC/MEM/WB with a
// bounded memory handshake and a sticky trap state.
module multicycle_control_unit
  import kgp_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int FNW  = 6,
  parameter int ALUW = 3,
  parameter int TMO  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  instruction,
  input  logic [FNW-1:0]  fn,
  input  logic            mem_ack,
  input  logic            flag_ok,
  output logic            ir_write,
  output logic            pc_write,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      regdst,
  output logic [1:0]      flag,
  output logic            branch,
  output logic            brnoeq,
  output logic            gotoreg,
  output logic            onlygoto,
  output logic            call,
  output logic            ret,
  output logic            memtoreg,
  output logic [1:0]      alusrc,
  output logic [ALUW-1:0] aluctr,
  output logic            regwrite,
  output logic            trap,
  output logic [2:0]      state_o
);

  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

  state_t          state_reg, state_next;
  ctl_t            ctl_reg, ctl_next, dec_ctl;
  logic            dec_illegal;
  logic            mem_req_reg, mem_req_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            acked, timeout;

  kgp_decoder #(.OPW(OPW), .FNW(FNW)) u_dec (
    .instruction (instruction),
    .fn          (fn),
    .ctl         (dec_ctl),
    .illegal     (dec_illegal)
  );

  // An ack only counts while a request is actually outstanding.
  assign acked   = mem_req_reg & mem_ack;
  assign timeout = mem_req_reg & ~mem_ack & (cnt_reg == CW'(TMO - 1));

  always_comb begin
    state_next = state_reg;
    ctl_next   = ctl_reg;
    cnt_next   = '0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    regwrite   = 1'b0;
    if (mem_req_reg && !mem_ack)
      cnt_next = cnt_reg + 1'b1;
    case (state_reg)
      ST_FETCH: begin
        if (acked) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_next = ST_TRAP;
        end else begin
          ctl_next   = dec_ctl;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (ctl_reg.cls)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_BRANCH: begin
            pc_write   = ctl_reg.branch ? flag_ok : 1'b1;
            state_next = ctl_reg.call ? ST_WB : ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (acked)
          state_next = (ctl_reg.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout)
          state_next = ST_TRAP;
      end
      ST_WB: begin
        regwrite   = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_TRAP;
    endcase
    if (state_next == ST_FETCH || state_next == ST_TRAP)
      ctl_next = CTL_NONE;
    mem_req_next = (state_next == ST_FETCH) || (state_next == ST_MEM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_FETCH;
      ctl_reg     <= CTL_NONE;
      mem_req_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      ctl_reg     <= ctl_next;
      mem_req_reg <= mem_req_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign mem_req  = mem_req_reg;
  assign mem_we   = mem_req_reg & (state_reg == ST_MEM) & (ctl_reg.cls == CLS_STORE);
  assign regdst   = ctl_reg.regdst;
  assign flag     = ctl_reg.flag;
  assign branch   = ctl_reg.branch;
  assign brnoeq   = ctl_reg.brnoeq;
  assign gotoreg  = ctl_reg.gotoreg;
  assign onlygoto = ctl_reg.onlygoto;
  assign call     = ctl_reg.call;
  assign ret      = ctl_reg.ret;
  assign memtoreg = ctl_reg.memtoreg;
  assign alusrc   = ctl_reg.alusrc;
  assign aluctr   = ALUW'(ctl_reg.aluctr);
  assign trap     = (state_reg == ST_TRAP);
  assign state_o  = state_reg;

endmodule
